// File: rtl/early_dbc_pkg.sv
// Shared types and default parameters for the early-detection debouncer.
// Optional input synchronisers are enabled with EARLY_DBC_SYNC_EN.
package early_dbc_pkg;

  typedef enum logic [1:0] {
    DBC_ZERO  = 2'd0,
    DBC_WAIT1 = 2'd1,
    DBC_ONE   = 2'd2,
    DBC_WAIT0 = 2'd3
  } dbc_state_t;

  localparam int DEF_N          = 4;
  localparam int DEF_TICK_M     = 1_000_000;
  localparam int DEF_WAIT_TICKS = 3;

endpackage

// File: rtl/early_dbc_chan.sv
// One debounce channel: edge-reacting Moore FSM, blanking counter
// and rise/fall edge register.
module early_dbc_chan
  import early_dbc_pkg::*;
#(
  parameter int WAIT_TICKS = DEF_WAIT_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_s,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(WAIT_TICKS + 1);
  localparam logic [CW-1:0] LOAD = CW'(WAIT_TICKS);
  localparam logic [CW-1:0] LAST = CW'(1);

  dbc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic db_q, db_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DBC_ZERO: begin
        if (btn_s) begin
          state_d = DBC_WAIT1;
          cnt_d   = LOAD;
        end
      end
      DBC_WAIT1, DBC_WAIT0: begin
        // input is only looked at on the last tick of the window
        if (tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LAST) begin
            state_d = btn_s ? DBC_ONE : DBC_ZERO;
          end
        end
      end
      DBC_ONE: begin
        if (!btn_s) begin
          state_d = DBC_WAIT0;
          cnt_d   = LOAD;
        end
      end
      default: begin
        state_d = DBC_ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  assign db   = (state_q == DBC_WAIT1) || (state_q == DBC_ONE);
  assign db_d = db;
  assign rise = db & ~db_q;
  assign fall = ~db & db_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DBC_ZERO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

endmodule

// File: rtl/early_dbc_array.sv
// N-channel early-detection debouncer with one shared tick prescaler.
// Define EARLY_DBC_SYNC_EN to put a 2-flop synchroniser on each btn bit.
module early_dbc_array
  import early_dbc_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int TICK_M     = DEF_TICK_M,
  parameter int WAIT_TICKS = DEF_WAIT_TICKS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] btn,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int PW = $clog2(TICK_M);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_M - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [N-1:0]  btn_s;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

`ifdef EARLY_DBC_SYNC_EN
  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;

  assign sync1_d = btn;
  assign sync2_d = sync1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = btn;
`endif

  for (genvar g = 0; g < N; g++) begin : g_chan
    early_dbc_chan #(
      .WAIT_TICKS(WAIT_TICKS)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .btn_s  (btn_s[g]),
      .db     (db[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

endmodule

// File: tb/tb_early_dbc_array.sv
// Self-checking bench for early_dbc_array (N=2, TICK_M=4, WAIT_TICKS=3).
// Reference model: per-channel level plus ticks-left-in-blanking counter.
module tb_early_dbc_array;

  localparam int N = 2;
  localparam int M = 4;
  localparam int W = 3;
`ifdef EARLY_DBC_SYNC_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn;
  logic [N-1:0] db, rise, fall;

  always #5 clk = ~clk;

  early_dbc_array #(
    .N         (N),
    .TICK_M    (M),
    .WAIT_TICKS(W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (btn),
    .db     (db),
    .rise   (rise),
    .fall   (fall)
  );

  int checks = 0;
  int passed = 0;

  // reference model state
  int           pcnt;
  logic [N-1:0] lvl;
  int           blank [N];
  logic [N-1:0] s1, s2;
  logic [N-1:0] exp_db, exp_rise, exp_fall;

  // observed pulse / level counters
  int rc [N];
  int fc [N];
  int hc [N];

  task automatic model_reset();
    pcnt = 0;
    lvl  = '0;
    s1   = '0;
    s2   = '0;
    for (int i = 0; i < N; i++) blank[i] = 0;
    exp_db   = '0;
    exp_rise = '0;
    exp_fall = '0;
  endtask

  task automatic model_step(input logic [N-1:0] b);
    logic [N-1:0] fin, old;
    bit tk;
`ifdef EARLY_DBC_SYNC_EN
    fin = s2;
    s2  = s1;
    s1  = b;
`else
    fin = b;
`endif
    tk  = (pcnt == M - 1);
    old = lvl;
    for (int i = 0; i < N; i++) begin
      if (blank[i] == 0) begin
        if (fin[i] !== lvl[i]) begin
          lvl[i]   = fin[i];
          blank[i] = W;
        end
      end else if (tk) begin
        blank[i]--;
        if (blank[i] == 0) lvl[i] = fin[i];
      end
    end
    pcnt     = (pcnt + 1) % M;
    exp_db   = lvl;
    exp_rise = lvl & ~old;
    exp_fall = ~lvl & old;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < N; i++) begin
      rc[i] = 0;
      fc[i] = 0;
      hc[i] = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] b);
    btn = b;
    @(posedge clk);
    model_step(b);
    #1;
    for (int i = 0; i < N; i++) begin
      rc[i] += int'(rise[i]);
      fc[i] += int'(fall[i]);
      hc[i] += int'(db[i]);
    end
  endtask

  task automatic do_reset();
    btn     = '0;
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn     = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({db, rise, fall} !== '0)
        $display("FAIL reset c=%0d db=%b rise=%b fall=%b want all 0",
                 c, db, rise, fall);
      else passed++;
    end
    btn     = '0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_clean_press();
    int first_hi;
    do_reset();
    clr_cnt();
    first_hi = 0;
    for (int c = 1; c <= 30; c++) begin
      step((c >= 11) ? 2'b01 : 2'b00);
      if (db[0] && first_hi == 0) first_hi = c;
      checks++;
      if ({db, rise, fall} !== {exp_db, exp_rise, exp_fall})
        $display("FAIL press c=%0d got %b/%b/%b want %b/%b/%b",
                 c, db, rise, fall, exp_db, exp_rise, exp_fall);
      else passed++;
    end
    checks++;
    if (first_hi !== 11 + SLAT)
      $display("FAIL press_lat got %0d want %0d", first_hi, 11 + SLAT);
    else passed++;
    checks++;
    if (rc[0] !== 1 || fc[0] !== 0 || hc[1] !== 0 || rc[1] !== 0)
      $display("FAIL press_cnt rise0=%0d fall0=%0d hi1=%0d rise1=%0d want 1 0 0 0",
               rc[0], fc[0], hc[1], rc[1]);
    else passed++;
  endtask

  task automatic test_glitch();
    do_reset();
    for (int c = 0; c < 5; c++) step(2'b00);
    clr_cnt();
    for (int c = 0; c < 25; c++) begin
      step((c == 0) ? 2'b01 : 2'b00);
      checks++;
      if ({db, rise, fall} !== {exp_db, exp_rise, exp_fall})
        $display("FAIL glitch c=%0d got %b/%b/%b want %b/%b/%b",
                 c, db, rise, fall, exp_db, exp_rise, exp_fall);
      else passed++;
    end
    checks++;
    if (hc[0] < 9 || hc[0] > 12 || rc[0] !== 1 || fc[0] !== 1 || db[0] !== 1'b0)
      $display("FAIL glitch_len hi=%0d rise=%0d fall=%0d db=%b want 9..12 1 1 0",
               hc[0], rc[0], fc[0], db[0]);
    else passed++;
  endtask

  task automatic test_bouncy_release();
    do_reset();
    for (int c = 0; c < 20; c++) step(2'b01);
    clr_cnt();
    for (int c = 0; c < 30; c++) begin
      step((c < 8 && c[0]) ? 2'b01 : 2'b00);
      checks++;
      if ({db, rise, fall} !== {exp_db, exp_rise, exp_fall})
        $display("FAIL bounce c=%0d got %b/%b/%b want %b/%b/%b",
                 c, db, rise, fall, exp_db, exp_rise, exp_fall);
      else passed++;
    end
    checks++;
    if (fc[0] !== 1 || rc[0] !== 0 || db[0] !== 1'b0)
      $display("FAIL bounce_cnt fall=%0d rise=%0d db=%b want 1 0 0",
               fc[0], rc[0], db[0]);
    else passed++;
  endtask

  task automatic test_repress();
    do_reset();
    for (int c = 0; c < 20; c++) step(2'b01);
    clr_cnt();
    for (int c = 0; c < 30; c++) begin
      step((c < 3) ? 2'b00 : 2'b11);
      checks++;
      if ({db, rise, fall} !== {exp_db, exp_rise, exp_fall})
        $display("FAIL repress c=%0d got %b/%b/%b want %b/%b/%b",
                 c, db, rise, fall, exp_db, exp_rise, exp_fall);
      else passed++;
    end
    checks++;
    if (fc[0] !== 1 || rc[0] !== 1 || rc[1] !== 1 || fc[1] !== 0 || db !== 2'b11)
      $display("FAIL repress_cnt f0=%0d r0=%0d r1=%0d f1=%0d db=%b want 1 1 1 0 11",
               fc[0], rc[0], rc[1], fc[1], db);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 3; c++) step(2'b00);
    for (int c = 0; c < 3 + SLAT; c++) step(2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({db, rise, fall} !== '0)
      $display("FAIL async_rst db=%b rise=%b fall=%b want all 0", db, rise, fall);
    else passed++;
    btn = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    clr_cnt();
    for (int c = 0; c < 15; c++) step(2'b00);
    checks++;
    if (hc[0] !== 0 || rc[0] !== 0)
      $display("FAIL async_idle hi=%0d rise=%0d want 0 0", hc[0], rc[0]);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      step(2'b01);
      checks++;
      if ({db, rise, fall} !== {exp_db, exp_rise, exp_fall})
        $display("FAIL async_press c=%0d got %b/%b/%b want %b/%b/%b",
                 c, db, rise, fall, exp_db, exp_rise, exp_fall);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] cur;
    do_reset();
    cur = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(4, 0) == 0) cur[i] = ~cur[i];
      step(cur);
      checks++;
      if ({db, rise, fall} !== {exp_db, exp_rise, exp_fall} || (rise & fall) !== '0)
        $display("FAIL random c=%0d got %b/%b/%b want %b/%b/%b",
                 c, db, rise, fall, exp_db, exp_rise, exp_fall);
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    btn     = '0;
    reset_n = 1'b0;
    model_reset();
    clr_cnt();
    test_reset();
    test_clean_press();
    test_glitch();
    test_bouncy_release();
    test_repress();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
